// File: rtl/adder_pipe.sv
// Pipelined two's-complement adder/subtractor: the WIDTH-bit carry chain is cut
// into STAGES chunks, one chunk resolved per clock, with valid-gated data registers.
module adder_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int C = WIDTH / STAGES;

   logic [STAGES-1:0] v_q, v_d;
   logic [STAGES-1:0] c_q, c_d;
   logic [WIDTH-1:0]  s_q [STAGES];
   logic [WIDTH-1:0]  s_d [STAGES];
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  a_d [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  b_d [STAGES];
   logic              ovf_q, ovf_d;

   // Stage k consumes the registers of stage k-1 (stage 0 consumes the ports);
   // b is inverted once at entry so later stages never need the sub flag.
   always_comb begin
      logic [WIDTH-1:0] a_src, b_src, s_src;
      logic             c_src, v_src;
      logic [C:0]       chunk;
      int               p;
      v_d   = v_q;
      c_d   = c_q;
      s_d   = s_q;
      a_d   = a_q;
      b_d   = b_q;
      ovf_d = ovf_q;
      a_src = '0;
      b_src = '0;
      s_src = '0;
      c_src = 1'b0;
      v_src = 1'b0;
      chunk = '0;
      p     = 0;
      for (int k = 0; k < STAGES; k++) begin
         p = (k == 0) ? 0 : k - 1;
         if (k == 0) begin
            a_src = a;
            b_src = sub ? ~b : b;
            s_src = '0;
            c_src = cin ^ sub;
            v_src = in_valid;
         end else begin
            a_src = a_q[p];
            b_src = b_q[p];
            s_src = s_q[p];
            c_src = c_q[p];
            v_src = v_q[p];
         end
         chunk  = {1'b0, a_src[k*C +: C]} + {1'b0, b_src[k*C +: C]} + {{C{1'b0}}, c_src};
         v_d[k] = v_src;
         if (v_src) begin
            a_d[k]            = a_src;
            b_d[k]            = b_src;
            s_d[k]            = s_src;
            s_d[k][k*C +: C]  = chunk[C-1:0];
            c_d[k]            = chunk[C];
            // carry into the MSB is a^b^sum at that bit; overflow is it XOR carry-out
            if (k == STAGES - 1) begin
               ovf_d = a_src[WIDTH-1] ^ b_src[WIDTH-1] ^ chunk[C-1] ^ chunk[C];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q   <= '0;
         c_q   <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            s_q[k] <= '0;
            a_q[k] <= '0;
            b_q[k] <= '0;
         end
      end else begin
         v_q   <= v_d;
         c_q   <= c_d;
         ovf_q <= ovf_d;
         for (int k = 0; k < STAGES; k++) begin
            s_q[k] <= s_d[k];
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
         end
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign s         = s_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
   assign ovf       = ovf_q;

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, fully pipelined two's-complement adder/subtractor for the arithmetic datapath; the multi-cycle successor to the fixed 4-bit ripple adder. The WIDTH-bit carry chain is split into STAGES equal chunks, one chunk per clock, so it closes timing at WIDTH the single-cycle adder cannot reach. It accepts one operation per cycle with a valid flag, supports add/subtract mode and carry/borrow-in, and reports unsigned carry-out and signed overflow.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of STAGES
- STAGES, 4, pipeline depth and number of carry-chain chunks; 1..WIDTH; chunk width C = WIDTH/STAGES
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous and active-high
- in_valid  in  1  operands on a/b/cin/sub are valid this cycle
- sub  in  1  0 = add, 1 = subtract
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (subtract)
- out_valid  out  1  s/cout/ovf carry a new result this cycle
- s  out  WIDTH  result
- cout  out  1  carry out of the MSB
- ovf  out  1  signed overflow

## Operation
- Effective operand: B' = sub ? ~b : b. Effective carry-in: c0 = cin ^ sub.
- Result: {cout, s} = a + B' + c0, computed modulo 2^WIDTH.
  - Add: s = a + b + cin.
  - Subtract with cin=0: s = a - b, and cout=1 means no borrow (a >= b unsigned).
  - Subtract with cin=1: s = a - b - 1.
- ovf = carry into the MSB XOR cout; equivalently, the signed result does not fit in WIDTH bits.
- Stage k (k = 0..STAGES-1):
  - Adds chunk k of a and B' plus the carry registered by stage k-1 (stage 0 uses c0).
  - Registers the C-bit partial sum and the chunk carry-out.
  - Carries forward the already-computed lower sum chunks and the not-yet-used upper operand chunks in delay registers.
- Valid flag travels down a STAGES-deep shift register beside the data.
- Data registers of a stage load only when that stage's valid bit is 1.
- When out_valid is 0, s/cout/ovf hold the last valid result. No bubbles or stale data ever appear on them.
- No backpressure: one new operation may be issued every cycle, and results leave in issue order.

## Timing
- Latency is exactly STAGES cycles. Operands sampled at the edge ending cycle t produce out_valid=1 with their result throughout cycle t+STAGES.
- Throughput is 1 operation per cycle. Back-to-back in_valid yields back-to-back out_valid.
- A gap of n cycles in in_valid gives an identical n-cycle gap in out_valid.
- STAGES=1: single registered adder with a latency of 1 cycle.
- Reset, asynchronous on rst high:
  - out_valid=0, s=0, cout=0, ovf=0.
  - All internal valid bits, partial sums, carries and delay registers clear.
  - Operations in flight are discarded and never emerge.
  - While rst is high, in_valid is ignored.
  - The first operation sampled after rst falls emerges STAGES cycles later.
- Simultaneous entry and exit: an operation entering while another leaves is legal and needs no arbitration.
- Wrap-around: results wrap modulo 2^WIDTH. Wrap is signalled only through cout and ovf.

## Test plan
- Reset then idle: with rst high, all outputs are 0. After release, with in_valid=0 for 10 cycles, out_valid stays 0 and s=0.
- Basic add (WIDTH=16, STAGES=4): a=0x0001, b=0x0002, cin=0, sub=0 -> exactly 4 cycles later out_valid=1, s=0x0003, cout=0, ovf=0. Outputs then hold 0x0003 while out_valid=0.
- Carry across every chunk boundary:
  - 0xFFFF+0x0001 -> s=0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 -> s=0x8000, cout=0, ovf=1.
  - 0x0000+0x0000 with cin=1 -> s=0x0001.
- Subtract:
  - 0x0005-0x0007 -> s=0xFFFE, cout=0, ovf=0.
  - 0x8000-0x0001 -> s=0x7FFF, cout=1, ovf=1.
  - 0x0005-0x0003 with cin=1 -> s=0x0001, cout=1.
- Streaming: issue 8 random operations back-to-back, then 2 idle cycles, then 3 more. The out_valid pattern is the same as in_valid delayed by 4, and every result matches a reference model in order. Repeat the run with STAGES=1 and with WIDTH=32, STAGES=8.
- Reset mid-operation: pulse rst asynchronously (between edges) while 3 operations are in flight -> all outputs go to 0 immediately. None of the 3 operations ever appears, and the next operation issued after release emerges normally 4 cycles later.
